// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV64M divider.
package div_pkg;
    localparam int DIV_XLEN    = 64;
    localparam int DIV_LATENCY = DIV_XLEN + 2;

    typedef enum logic [1:0] {
        DIV_S = 2'b00,
        DIV_U = 2'b01,
        REM_S = 2'b10,
        REM_U = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step on unsigned magnitudes.
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);
    logic [XLEN:0] rem_shift;
    logic          ge;

    // The shifted remainder is kept XLEN+1 wide for the compare; after a
    // successful subtract the difference always fits back into XLEN bits.
    assign rem_shift = {rem_in, quo_in[XLEN-1]};
    assign ge        = rem_shift >= {1'b0, divisor};
    assign rem_out   = ge ? (rem_shift[XLEN-1:0] - divisor) : rem_shift[XLEN-1:0];
    assign quo_out   = {quo_in[XLEN-2:0], ge};
endmodule

// File: rtl/iter_divider_64bit.sv
// Multi-cycle DIV/DIVU/REM/REMU unit: one restoring step per cycle, with a
// fast path for divide-by-zero and signed overflow.
module iter_divider_64bit
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in DONE.
    div_state_t      state_q, state_d;
    logic            is_rem_q, neg_quo_q, neg_rem_q, out_valid_q;
    logic [XLEN-1:0] rem_q, quo_q, dvsr_q, result_q;
    logic [CW-1:0]   count_q;

    div_op_t         op_in;
    logic            in_signed, a_neg, b_neg, div_zero, overflow;
    logic [XLEN-1:0] abs_a, abs_b, step_rem, step_quo, quo_fix, rem_fix;

    assign op_in     = div_op_t'(op);
    assign in_signed = (op_in == DIV_S) || (op_in == REM_S);
    assign a_neg     = in_signed & dividend[XLEN-1];
    assign b_neg     = in_signed & divisor[XLEN-1];
    assign abs_a     = a_neg ? -dividend : dividend;
    assign abs_b     = b_neg ? -divisor : divisor;
    assign div_zero  = (divisor == '0);
    assign overflow  = in_signed && (dividend == MIN_INT) && (divisor == '1);
    assign quo_fix   = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix   = neg_rem_q ? -rem_q : rem_q;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (div_zero || overflow) ? DONE : CALC;
            CALC: if (count_q == CW'(XLEN - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush kills any operation and also blocks a same-edge accept in IDLE.
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_rem_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            out_valid_q <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            result_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (in_valid) begin
                        is_rem_q  <= op[1];
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (div_zero) begin
                            result_q <= op[1] ? dividend : '1;
                        end else if (overflow) begin
                            result_q <= op[1] ? '0 : MIN_INT;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= abs_a;
                            dvsr_q  <= abs_b;
                            count_q <= '0;
                        end
                    end
                    CALC: begin
                        rem_q   <= step_rem;
                        quo_q   <= step_quo;
                        count_q <= count_q + 1'b1;
                    end
                    FIX:  result_q <= is_rem_q ? rem_fix : quo_fix;
                    // out_valid rises one cycle after DONE is entered.
                    DONE: out_valid_q <= !(out_valid_q && out_ready);
                    default: out_valid_q <= 1'b0;
                endcase
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule
